// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs and pipeline hold/bubble controls.
// The slave side is the hazard_ctrl block; the master side is the core datapath.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_Rn;
  logic [4:0]       id_Rm;
  logic             id_useRm;
  logic             ex_MemRead;
  logic [4:0]       ex_waddr;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic             pc_sel_branch;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_Rn, id_Rm, id_useRm, ex_MemRead, ex_waddr, ex_branch_taken, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           pc_sel_branch, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_Rn, id_Rm, id_useRm, ex_MemRead, ex_waddr, ex_branch_taken, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           pc_sel_branch, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freezes and a watchdog. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_ctrl #(
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, LU, FREEZE} state_t;

  localparam logic [2:0]  LU_RELOAD = 3'(LU_BUBBLES - 1);
  localparam logic [15:0] WD_LIMIT  = 16'(WAIT_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ret_lu_q, ret_lu_d;
  logic [15:0] wd_q;
  logic        to_q;
  logic        lu_haz;
  logic        in_lu;
  logic        pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
  logic        idex_flush_c, exmem_stall_c, pc_sel_c;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign lu_haz = hz.ex_MemRead && (hz.ex_waddr != 5'd31) &&
                  ((hz.ex_waddr == hz.id_Rn) || (hz.id_useRm && (hz.ex_waddr == hz.id_Rm)));

  // A freeze entered from LU resumes the bubble sequence with the held count.
  assign in_lu = (state_q == LU) || ((state_q == FREEZE) && ret_lu_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      ret_lu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ret_lu_q <= ret_lu_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ret_lu_d      = ret_lu_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_stall_c = 1'b0;
    pc_sel_c      = 1'b0;
    if (hz.mem_busy) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_stall_c  = 1'b1;
      exmem_stall_c = 1'b1;
      state_d       = FREEZE;
      ret_lu_d      = in_lu;
    end else if (hz.ex_branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      pc_sel_c     = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
      ret_lu_d     = 1'b0;
    end else if (in_lu) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      ret_lu_d     = 1'b0;
      if (cnt_q <= 3'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = LU;
        cnt_d   = cnt_q - 3'd1;
      end
    end else if (lu_haz) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      ret_lu_d     = 1'b0;
      if (LU_BUBBLES > 1) begin
        state_d = LU;
        cnt_d   = LU_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d  = RUN;
      ret_lu_d = 1'b0;
    end
  end

  // Watchdog saturates at the limit so a long freeze cannot wrap it back below.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (hz.mem_busy) begin
      if (wd_q != WD_LIMIT) wd_q <= wd_q + 16'd1;
      if (wd_q >= WD_LIMIT - 16'd1) to_q <= 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall_c && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (pc_sel_c && (flush_q != '1))   flush_q <= flush_q + 1'b1;
    end
  end
`else
  assign stall_q = '0;
  assign flush_q = '0;
`endif

  assign hz.pc_stall      = pc_stall_c    & ~rst;
  assign hz.ifid_stall    = ifid_stall_c  & ~rst;
  assign hz.ifid_flush    = ifid_flush_c  & ~rst;
  assign hz.idex_stall    = idex_stall_c  & ~rst;
  assign hz.idex_flush    = idex_flush_c  & ~rst;
  assign hz.exmem_stall   = exmem_stall_c & ~rst;
  assign hz.pc_sel_branch = pc_sel_c      & ~rst;
  assign hz.mem_timeout   = to_q          & ~rst;
  assign hz.stall_cnt     = rst ? '0 : stall_q;
  assign hz.flush_cnt     = rst ? '0 : flush_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall/flush controller for the 5-stage ARMv8 core.
- Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their hold (stall) and bubble (flush) controls.
- Sequences load-use bubbles, taken-branch flushes and whole-pipe freezes on data-memory wait.
- Keeps a watchdog on memory wait and, optionally, performance counters.

Parameters:
- LU_BUBBLES, 1: bubbles inserted per load-use hazard (1..7).
- WAIT_TIMEOUT, 255: consecutive mem_busy cycles before mem_timeout is set (1..65535).
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_Rn  in  5  ID-stage source register 1 address
- id_Rm  in  5  ID-stage source register 2 address
- id_useRm  in  1  ID instruction reads Rm
- ex_MemRead  in  1  EX-stage instruction is a load
- ex_waddr  in  5  EX-stage destination register
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory not ready
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  load NOP into ID/EX
- exmem_stall  out  1  hold EX/MEM
- pc_sel_branch  out  1  select branch target into PC
- mem_timeout  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  bubble + freeze cycle count
- flush_cnt  out  CNT_W  branch flush count

Behaviour:
- Clocking: one clock, clk. Synchronous active-high reset, rst. State and counters update only on posedge clk.
- Control outputs are combinational from current state and inputs, so they act in the same cycle.
- Reset: while rst=1, every output is 0. Next state is RUN, bubble counter is 0, watchdog is 0, mem_timeout is 0, stall_cnt and flush_cnt are 0. Reset mid-stall or mid-freeze abandons the sequence.
- Hazard definition: lu_haz = ex_MemRead & (ex_waddr != 31) & ((ex_waddr == id_Rn) | (id_useRm & ex_waddr == id_Rm)). X31/XZR never causes a hazard.
- States: RUN, LU, FREEZE.
- Priority within any state: mem_busy > ex_branch_taken > lu_haz / LU.
- mem_busy=1, any state:
  - pc_stall, ifid_stall, idex_stall, exmem_stall = 1. All flushes and pc_sel_branch = 0.
  - Enter FREEZE. Save the LU bubble count (held, not decremented).
- FREEZE with mem_busy=0: return to the saved state (RUN, or LU with held count). Outputs for that cycle are evaluated as in the returned state.
- ex_branch_taken=1 (no busy):
  - ifid_flush = idex_flush = pc_sel_branch = 1. Stalls = 0.
  - Any pending LU is cancelled and the bubble count is cleared; next state RUN.
  - flush_cnt increments.
- RUN with lu_haz (no busy, no branch):
  - pc_stall = ifid_stall = idex_flush = 1. This is bubble 1.
  - If LU_BUBBLES > 1: go to LU with count = LU_BUBBLES-1. Otherwise stay in RUN.
- LU: same outputs as the RUN lu_haz case. Count decrements each cycle; at count==1, next state is RUN. lu_haz is not re-evaluated in LU.
- Watchdog:
  - Increments each cycle mem_busy=1, clears when mem_busy=0, saturates.
  - When it reaches WAIT_TIMEOUT, mem_timeout sets and stays set until rst.
  - Pipeline keeps freezing; no forced release.
- Counters (see Optional Feature):
  - stall_cnt increments on every cycle with pc_stall=1.
  - Both counters saturate at all-ones; no wrap.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: no counter registers; stall_cnt and flush_cnt are tied to 0. All control behaviour is identical.

Test Plan:
- Load-use: ex_MemRead=1, ex_waddr=5, id_Rn=5, LU_BUBBLES=1 -> one cycle of pc_stall/ifid_stall/idex_flush=1, then all 0; stall_cnt=1.
- XZR and Rm gating:
  - ex_waddr=31=id_Rn -> no stall.
  - ex_waddr=7=id_Rm with id_useRm=0 -> no stall.
  - ex_waddr=7=id_Rm with id_useRm=1 -> stall.
- LU_BUBBLES=3 with hazard; mem_busy=1 for 2 cycles in the 2nd bubble -> 3 bubble cycles plus 2 freeze cycles (all four stalls=1, no flush); stall_cnt=5.
- Branch during LU: LU_BUBBLES=3, ex_branch_taken=1 in 2nd bubble -> that cycle ifid_flush=idex_flush=pc_sel_branch=1; next cycle all 0; flush_cnt=1.
- Watchdog: WAIT_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout rises after the 4th busy cycle, stays 1 after busy drops, clears only on rst.
- Saturation/reset: CNT_W=4, 20 stall cycles -> stall_cnt=15. Assert rst mid-LU -> all outputs 0 next cycle; state RUN.
